ifm_bank_writer: RTL
====================

Name: ifm_bank_writer

Overview:
- Write-side front end for the 16-bank IFM dual-port RAM.
- Accepts a valid/ready stream of packed input-feature-map words (one byte per bank) from the DMA/loader.
- Drives one RAM write port per bank: per-bank write enable, per-bank address and packed write data.
- Counts lines, wraps addresses at ADDR_LINE, checks stream framing, and reports completion to the layer controller.

Parameters:
- ADDR_WIDTH, 19, bank address width.
- ADDR_LINE, 519168, lines per bank; valid addresses are 0..ADDR_LINE-1.
- DATA_WIDTH, 8, bits per bank element.
- NUM_BANKS, 16, number of banks, one byte lane per bank.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; sampled in IDLE only.
- base_addr  in  ADDR_WIDTH  first line address; latched on accepted start.
- num_lines  in  ADDR_WIDTH  number of words to write; latched on accepted start.
- bank_mask  in  NUM_BANKS  per-bank write enable mask; latched on accepted start.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_WIDTH*NUM_BANKS  stream word; lane i = s_data[i*DATA_WIDTH +: DATA_WIDTH].
- s_last  in  1  marks the final word of the transfer.
- s_ready  out  1  writer can accept a word.
- we  out  NUM_BANKS  per-bank write enable to the RAM port.
- addr  out  ADDR_WIDTH*NUM_BANKS  per-bank address; bank i = addr[i*ADDR_WIDTH +: ADDR_WIDTH].
- din  out  DATA_WIDTH*NUM_BANKS  packed write data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- last_err  out  1  sticky framing error; cleared on the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; s_ready, we, busy, done, last_err = 0; addr, din, all counters = 0.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 latches base_addr, num_lines and bank_mask; clears line_cnt and last_err.
  - If num_lines != 0: go to RUN.
  - If num_lines == 0: go to FLUSH; no writes are issued.
- RUN:
  - s_ready = 1.
  - Handshake is s_valid & s_ready. Each handshake registers the word into the output stage.
  - Next cycle: we = bank_mask; every bank gets the same address cur_addr; din = the accepted word.
  - Latency is exactly 1 cycle from handshake to we. Throughput is 1 word per cycle.
  - we = 0 in any cycle following a cycle with no handshake; addr and din hold their last values.
- Address arithmetic:
  - cur_addr starts at base_addr and increments by 1 per handshake.
  - When cur_addr == ADDR_LINE-1, the next value is 0 (no overflow beyond ADDR_LINE-1).
  - base_addr >= ADDR_LINE is reduced once at start: base_addr - ADDR_LINE.
- Line counting: line_cnt increments per handshake. The handshake with line_cnt == num_lines-1 is the final word; it moves the FSM to FLUSH and s_ready drops the next cycle.
- Framing check: last_err is set if s_last=1 on a non-final handshake, or s_last=0 on the final handshake. The transfer still completes by count, not by s_last.
- FLUSH:
  - Lasts one cycle; the final write's we is visible during it.
  - done pulses 1 for one cycle in the cycle after FLUSH. busy drops in the same cycle. FSM returns to IDLE.
  - For num_lines=0, done pulses 2 cycles after start.
- busy = 1 in RUN and FLUSH only.
- start outside IDLE is ignored; latched parameters are unaffected.
- s_valid outside RUN: s_ready=0, no handshake, data is not consumed.
- Async reset mid-transfer: all outputs drop immediately, including we; the partially written RAM content is undefined for the controller.

Test Plan:
- Reset then start, base_addr=0, num_lines=4, bank_mask=16'hFFFF, 4 back-to-back words with s_last on the 4th -> we=FFFF on 4 consecutive cycles, each one cycle after its handshake, addr 0,1,2,3 on all banks; done pulses 2 cycles after the last handshake; last_err=0.
- base_addr=519166, num_lines=3 -> bank addresses 519166, 519167, 0.
- s_valid toggled 1,0,1,1,0,1 with num_lines=4 -> we high only in cycles after handshakes; addr 0..3 with no gaps in sequence; addr/din held during bubbles.
- bank_mask=16'h00F0 -> we[7:4] only; din lane 5 equals s_data[47:40].
- s_last asserted on word 2 of 4 -> last_err=1, all 4 words written, done pulses; next start clears last_err.
- num_lines=0 -> no we, done 2 cycles after start. Separately, start pulsed during RUN -> ignored. rst_n low mid-transfer -> we, busy, s_ready = 0 asynchronously; IDLE after release.

Source files
------------

// File: rtl/ifm_bank_writer.sv
// Write-side front end for the 16-bank IFM RAM: accepts a valid/ready stream of
// packed words and issues one registered write per handshake to every masked bank.
module ifm_bank_writer #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned ADDR_LINE  = 519168,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_BANKS  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [ADDR_WIDTH-1:0]            num_lines,
    input  logic [NUM_BANKS-1:0]             bank_mask,
    input  logic                             s_valid,
    input  logic [DATA_WIDTH*NUM_BANKS-1:0]  s_data,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic [NUM_BANKS-1:0]             we,
    output logic [ADDR_WIDTH*NUM_BANKS-1:0]  addr,
    output logic [DATA_WIDTH*NUM_BANKS-1:0]  din,
    output logic                             busy,
    output logic                             done,
    output logic                             last_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LINE_A = ADDR_WIDTH'(ADDR_LINE);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(ADDR_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

    logic [1:0]                      state_q,    state_d;
    logic [ADDR_WIDTH-1:0]           cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0]           num_q,      num_d;
    logic [NUM_BANKS-1:0]            mask_q,     mask_d;
    logic [ADDR_WIDTH-1:0]           cnt_q,      cnt_d;
    logic [NUM_BANKS-1:0]            we_q,       we_d;
    logic [ADDR_WIDTH-1:0]           addr_q,     addr_d;
    logic [DATA_WIDTH*NUM_BANKS-1:0] din_q,      din_d;
    logic                            done_q,     done_d;
    logic                            err_q,      err_d;

    logic hs;
    logic is_final;

    assign hs       = s_valid && (state_q == S_RUN);
    assign is_final = (cnt_q == (num_q - ONE_A));

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        num_d      = num_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        we_d       = '0;
        addr_d     = addr_q;
        din_d      = din_q;
        done_d     = (state_q == S_FLUSH);
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = num_lines;
                    mask_d     = bank_mask;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    // Out-of-range base is folded back into the bank once, at start.
                    cur_addr_d = (base_addr >= LINE_A) ? (base_addr - LINE_A) : base_addr;
                    state_d    = (num_lines != '0) ? S_RUN : S_FLUSH;
                end
            end
            S_RUN: begin
                if (hs) begin
                    we_d       = mask_q;
                    addr_d     = cur_addr_q;
                    din_d      = s_data;
                    cur_addr_d = (cur_addr_q == LAST_A) ? '0 : (cur_addr_q + ONE_A);
                    cnt_d      = cnt_q + ONE_A;
                    if (s_last != is_final) begin
                        err_d = 1'b1;
                    end
                    if (is_final) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            num_q      <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            we_q       <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            num_q      <= num_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign s_ready  = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign we       = we_q;
    assign addr     = {NUM_BANKS{addr_q}};
    assign din      = din_q;
    assign done     = done_q;
    assign last_err = err_q;

endmodule
